// File: rtl/writeback_stage.sv
// MEM/WB pipeline register, load formatter and writeback result select.
// Drives the register-file write port and counts retired instructions.
module writeback_stage #(
  parameter int NUM_SRC  = 4,
  parameter int RETIRE_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                stall_i,
  input  logic                flush_i,
  input  logic                ValidM_i,
  input  logic                RegWriteM_i,
  input  logic [4:0]          RdM_i,
  input  logic [1:0]          ResultSrcM_i,
  input  logic [2:0]          Funct3M_i,
  input  logic [31:0]         ALUResultM_i,
  input  logic [31:0]         ReadDataM_i,
  input  logic [31:0]         PCPlus4M_i,
  input  logic [31:0]         ImmExtM_i,
  output logic [31:0]         ResultW_o,
  output logic [4:0]          RdW_o,
  output logic                RegWriteW_o,
  output logic                ValidW_o,
  output logic [RETIRE_W-1:0] RetireCountW_o
);

  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic [4:0]  rd;
    logic [1:0]  src;
    logic [2:0]  funct3;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] pc4;
    logic [31:0] imm;
  } mem_wb_t;

  mem_wb_t             wb_q;
  logic [RETIRE_W-1:0] retire_q;
  logic [7:0]          byte_sel;
  logic [15:0]         half_sel;
  logic [31:0]         load_data;
  logic [31:0]         result;

  // MEM/WB register: reset, then flush bubble, then stall hold, then capture
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb_q <= '0;
    end else if (flush_i) begin
      wb_q <= '0;
    end else if (!stall_i) begin
      wb_q <= '{
        valid:    ValidM_i,
        regwrite: RegWriteM_i,
        rd:       RdM_i,
        src:      ResultSrcM_i,
        funct3:   Funct3M_i,
        alu:      ALUResultM_i,
        rdata:    ReadDataM_i,
        pc4:      PCPlus4M_i,
        imm:      ImmExtM_i
      };
    end
  end

  // Retire counter counts the instruction leaving W unless held by a stall
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      retire_q <= '0;
    end else if (wb_q.valid && !stall_i) begin
      retire_q <= retire_q + RETIRE_W'(1);
    end
  end

  // Pick byte and halfword lanes from the registered offset
  always_comb begin
    byte_sel = wb_q.rdata[7:0];
    case (wb_q.alu[1:0])
      2'd0: byte_sel = wb_q.rdata[7:0];
      2'd1: byte_sel = wb_q.rdata[15:8];
      2'd2: byte_sel = wb_q.rdata[23:16];
      2'd3: byte_sel = wb_q.rdata[31:24];
      default: byte_sel = wb_q.rdata[7:0];
    endcase
    half_sel = wb_q.alu[1] ? wb_q.rdata[31:16] : wb_q.rdata[15:0];
  end

  // Size and sign extension of load data; odd halfword offset is ignored
  always_comb begin
    load_data = wb_q.rdata;
    case (wb_q.funct3)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_data = {24'b0, byte_sel};
      3'b101:  load_data = {16'b0, half_sel};
      default: load_data = wb_q.rdata;
    endcase
  end

  // Result select; sources beyond NUM_SRC read as zero
  always_comb begin
    result = '0;
    if (32'(wb_q.src) < 32'(NUM_SRC)) begin
      case (wb_q.src)
        2'd0:    result = wb_q.alu;
        2'd1:    result = load_data;
        2'd2:    result = wb_q.pc4;
        2'd3:    result = wb_q.imm;
        default: result = '0;
      endcase
    end
  end

  assign ResultW_o      = result;
  assign RdW_o          = wb_q.rd;
  assign RegWriteW_o    = wb_q.valid & wb_q.regwrite & (wb_q.rd != 5'd0);
  assign ValidW_o       = wb_q.valid;
  assign RetireCountW_o = retire_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage.
// Three instances share stimulus: default, NUM_SRC=3, RETIRE_W=4.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        valid = 1'b0;
  logic        regwrite = 1'b0;
  logic [4:0]  rd = '0;
  logic [1:0]  src = '0;
  logic [2:0]  funct3 = '0;
  logic [31:0] alu = '0;
  logic [31:0] rdata = '0;
  logic [31:0] pc4 = '0;
  logic [31:0] imm = '0;

  logic [31:0] result, result3, result4;
  logic [4:0]  rd_w, rd_w3, rd_w4;
  logic        we, we3, we4;
  logic        vw, vw3, vw4;
  logic [31:0] cnt, cnt3;
  logic [3:0]  cnt4;

  int n_cmp = 0;
  int n_bad = 0;
  bit mv = 1'b0;
  int mc = 0;

  always #5 clk = ~clk;

  writeback_stage #(.NUM_SRC(4), .RETIRE_W(32)) dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
    .ValidM_i(valid), .RegWriteM_i(regwrite), .RdM_i(rd),
    .ResultSrcM_i(src), .Funct3M_i(funct3), .ALUResultM_i(alu),
    .ReadDataM_i(rdata), .PCPlus4M_i(pc4), .ImmExtM_i(imm),
    .ResultW_o(result), .RdW_o(rd_w), .RegWriteW_o(we),
    .ValidW_o(vw), .RetireCountW_o(cnt)
  );

  writeback_stage #(.NUM_SRC(3), .RETIRE_W(32)) dut3 (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
    .ValidM_i(valid), .RegWriteM_i(regwrite), .RdM_i(rd),
    .ResultSrcM_i(src), .Funct3M_i(funct3), .ALUResultM_i(alu),
    .ReadDataM_i(rdata), .PCPlus4M_i(pc4), .ImmExtM_i(imm),
    .ResultW_o(result3), .RdW_o(rd_w3), .RegWriteW_o(we3),
    .ValidW_o(vw3), .RetireCountW_o(cnt3)
  );

  writeback_stage #(.NUM_SRC(4), .RETIRE_W(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
    .ValidM_i(valid), .RegWriteM_i(regwrite), .RdM_i(rd),
    .ResultSrcM_i(src), .Funct3M_i(funct3), .ALUResultM_i(alu),
    .ReadDataM_i(rdata), .PCPlus4M_i(pc4), .ImmExtM_i(imm),
    .ResultW_o(result4), .RdW_o(rd_w4), .RegWriteW_o(we4),
    .ValidW_o(vw4), .RetireCountW_o(cnt4)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // advance one edge; mv/mc track expected W valid and retire count
  task automatic tick();
    if (rst) begin
      mv = 1'b0;
      mc = 0;
    end else begin
      if (mv && !stall) mc++;
      if (flush) mv = 1'b0;
      else if (!stall) mv = valid;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [4:0] r, input logic [1:0] s,
                     input logic [2:0] f3, input logic [31:0] a);
    valid = 1'b1;
    regwrite = 1'b1;
    rd = r;
    src = s;
    funct3 = f3;
    alu = a;
  endtask

  logic [31:0] cnt_hold;

  initial begin
    tick();
    tick();
    rst = 1'b0;
    chk("rst_res", result, 32'h0);
    chk("rst_rd", {27'b0, rd_w}, 32'h0);
    chk("rst_we", {31'b0, we}, 32'h0);
    chk("rst_vw", {31'b0, vw}, 32'h0);
    chk("rst_cnt", cnt, 32'h0);

    put(5'd5, 2'd0, 3'b010, 32'h0000_1234);
    tick();
    chk("alu_res", result, 32'h0000_1234);
    chk("alu_rd", {27'b0, rd_w}, 32'd5);
    chk("alu_we", {31'b0, we}, 32'h1);
    chk("alu_cnt0", cnt, 32'd0);
    valid = 1'b0;
    tick();
    chk("alu_cnt1", cnt, 32'd1);

    rdata = 32'h80FF_7F01;
    put(5'd1, 2'd1, 3'b000, 32'h3);
    tick();
    chk("lb3", result, 32'hFFFF_FF80);
    put(5'd1, 2'd1, 3'b100, 32'h1);
    tick();
    chk("lbu1", result, 32'h0000_007F);
    put(5'd1, 2'd1, 3'b001, 32'h2);
    tick();
    chk("lh2", result, 32'hFFFF_80FF);
    put(5'd1, 2'd1, 3'b101, 32'h0);
    tick();
    chk("lhu0", result, 32'h0000_7F01);
    put(5'd1, 2'd1, 3'b010, 32'h0);
    tick();
    chk("lw", result, 32'h80FF_7F01);
    chk("lw_n3", result3, 32'h80FF_7F01);

    pc4 = 32'h104;
    put(5'd2, 2'd2, 3'b010, 32'h0);
    tick();
    chk("pc4", result, 32'h104);
    imm = 32'hABCD_E000;
    put(5'd3, 2'd3, 3'b010, 32'h0);
    tick();
    chk("imm", result, 32'hABCD_E000);
    chk("imm_n3", result3, 32'h0);
    put(5'd0, 2'd0, 3'b010, 32'h55);
    tick();
    chk("x0_we", {31'b0, we}, 32'h0);
    chk("x0_vw", {31'b0, vw}, 32'h1);
    chk("cnt_mid", cnt, 32'(mc));

    put(5'd7, 2'd0, 3'b010, 32'h0000_CAFE);
    tick();
    chk("pre_stall", result, 32'h0000_CAFE);
    stall = 1'b1;
    cnt_hold = cnt;
    for (int i = 0; i < 3; i++) begin
      put(5'd9, 2'd2, 3'b000, 32'hDEAD_0000 + 32'(i));
      pc4 = 32'h200 + 32'(i);
      tick();
      chk("stl_res", result, 32'h0000_CAFE);
      chk("stl_rd", {27'b0, rd_w}, 32'd7);
      chk("stl_we", {31'b0, we}, 32'h1);
      chk("stl_cnt", cnt, cnt_hold);
    end
    flush = 1'b1;
    tick();
    chk("fl_vw", {31'b0, vw}, 32'h0);
    chk("fl_we", {31'b0, we}, 32'h0);
    chk("fl_cnt", cnt, cnt_hold);
    flush = 1'b0;
    stall = 1'b0;

    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      put(5'd4, 2'd0, 3'b010, 32'(i));
      tick();
    end
    chk("w4_15", {28'b0, cnt4}, 32'd15);
    valid = 1'b0;
    tick();
    chk("w4_wrap", {28'b0, cnt4}, 32'd0);
    chk("w32_16", cnt, 32'd16);
    chk("w_model", cnt, 32'(mc));

    put(5'd6, 2'd2, 3'b010, 32'h0);
    pc4 = 32'h0000_0F00;
    tick();
    chk("pre_rst", result, 32'h0000_0F00);
    stall = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    stall = 1'b0;
    chk("mrst_res", result, 32'h0);
    chk("mrst_rd", {27'b0, rd_w}, 32'h0);
    chk("mrst_we", {31'b0, we}, 32'h0);
    chk("mrst_vw", {31'b0, vw}, 32'h0);
    chk("mrst_cnt", cnt, 32'h0);
    chk("mrst_cnt4", {28'b0, cnt4}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
